// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
// Contents:
//   - bus widths
//   - memory opcode encoding (mem_op_e)
//   - access size classification (size_e)
//   - FSM state encoding (state_e)
//   - small opcode classification helpers used by the stage and the aligner
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    function automatic size_e op_size(input mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: op_size = SZ_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: op_size = SZ_HALF;
            MEM_LW, MEM_SW:          op_size = SZ_WORD;
            default:                 op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_mem_op(input mem_op_e op);
        is_mem_op = (op_size(op) != SZ_NONE);
    endfunction

    function automatic logic is_load_op(input mem_op_e op);
        is_load_op = (op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW});
    endfunction

    function automatic logic is_signed_load(input mem_op_e op);
        is_signed_load = (op inside {MEM_LB, MEM_LH});
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port.
// Signals:
//   req    request held high for the whole outstanding access
//   we     1 = store, 0 = load
//   addr   word-aligned byte address ([1:0] always 0)
//   be     byte enables, little-endian lanes
//   wdata  store data replicated across the enabled lanes
//   ack    one-cycle completion pulse
//   rdata  load data, valid together with ack
// Modports: master = memory stage, slave = memory.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);

endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the memory stage.
// Ports:
//   op          memory opcode
//   lane        address bits [1:0]
//   sdata       raw store data (rt value)
//   rdata       raw word returned by memory
//   be          byte enables for the access size and lane
//   wdata       store data replicated to every lane of its size
//   ldata       selected load lane, sign/zero extended
//   misaligned  halfword with lane[0]=1 or word with lane!=0
module mem_align
    import mem_stage_pkg::*;
(
    input  mem_op_e           op,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] sdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ldata,
    output logic              misaligned
);

    size_e             size;
    logic [DATA_W-1:0] shifted;

    assign size    = op_size(op);
    // Bring the addressed lane down to bit 0 before extension.
    assign shifted = rdata >> {lane, 3'b000};

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        be         = 4'b0000;
        wdata      = sdata;
        ldata      = rdata;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{sdata[7:0]}};
                ldata = is_signed_load(op) ? {{24{shifted[7]}}, shifted[7:0]}
                                           : {24'h0, shifted[7:0]};
            end
            SZ_HALF: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{sdata[15:0]}};
                ldata      = is_signed_load(op) ? {{16{shifted[15]}}, shifted[15:0]}
                                                : {16'h0, shifted[15:0]};
                misaligned = lane[0];
            end
            SZ_WORD: begin
                be         = 4'b1111;
                misaligned = |lane;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores on the data-memory port, waits
// for the acknowledge (with an optional timeout), and owns the MEM/WB register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, mem_op,
//   reg_write, alu_out,
//   dst_addr, dst_data       EX/MEM register contents
//   mem_fwd                  MEM-stage forwarding value (alu_out)
//   stall                    freeze the upstream pipeline this cycle
//   dmem                     data-memory port (master side)
//   wb_valid, wb_we,
//   wb_addr, wb_data         MEM/WB register
//   addr_err                 one-cycle pulse on a misaligned access
//   bus_err                  one-cycle pulse on an acknowledge timeout
// Parameters:
//   TIMEOUT  cycles to wait for ack before bus_err; 0 waits forever
//   CNT_W    timeout counter width, 2**CNT_W > TIMEOUT
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  mem_op_e           mem_op,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [REG_W-1:0]  dst_addr,
    input  logic [DATA_W-1:0] dst_data,
    output logic [DATA_W-1:0] mem_fwd,
    output logic              stall,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              addr_err,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    mem_op_e           op_q;
    logic [DATA_W-1:0] addr_q;
    logic [REG_W-1:0]  dst_q;
    logic              rw_q;

    mem_op_e           align_op;
    logic [1:0]        align_lane;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ldata;
    logic              misaligned;

    logic              in_mem;
    logic              issue;
    logic              addr_fault;
    logic              timeout_hit;

    // While waiting, the aligner extends the returned word using the latched
    // opcode and lane rather than whatever sits on the (frozen) inputs.
    assign align_op   = (state == S_WAIT) ? op_q : mem_op;
    assign align_lane = (state == S_WAIT) ? addr_q[1:0] : alu_out[1:0];

    mem_align u_align (
        .op         (align_op),
        .lane       (align_lane),
        .sdata      (dst_data),
        .rdata      (dmem.rdata),
        .be         (be),
        .wdata      (wdata),
        .ldata      (ldata),
        .misaligned (misaligned)
    );

    assign in_mem      = in_valid && is_mem_op(mem_op);
    assign issue       = (state == S_IDLE) && in_mem && !misaligned;
    assign addr_fault  = (state == S_IDLE) && in_mem && misaligned;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // The issuing cycle and every waiting cycle stall; the cycle in which the
    // access resolves (ack or timeout) releases the pipeline.
    assign stall   = issue || ((state == S_WAIT) && !dmem.ack && !timeout_hit);
    assign mem_fwd = alu_out;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= MEM_NONE;
            addr_q     <= '0;
            dst_q      <= '0;
            rw_q       <= 1'b0;
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.be    <= '0;
            dmem.wdata <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            addr_err   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            // Pulses and the bubble are the default; the cases below override.
            addr_err <= 1'b0;
            bus_err  <= 1'b0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (addr_fault) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= dst_addr;
                        wb_data  <= alu_out;
                        addr_err <= 1'b1;
                    end else if (issue) begin
                        state      <= S_WAIT;
                        cnt        <= '0;
                        op_q       <= mem_op;
                        addr_q     <= alu_out;
                        dst_q      <= dst_addr;
                        rw_q       <= reg_write;
                        dmem.req   <= 1'b1;
                        dmem.we    <= !is_load_op(mem_op);
                        dmem.addr  <= {alu_out[DATA_W-1:2], 2'b00};
                        dmem.be    <= be;
                        dmem.wdata <= wdata;
                    end else begin
                        wb_valid <= in_valid;
                        wb_we    <= in_valid && reg_write;
                        wb_addr  <= dst_addr;
                        wb_data  <= alu_out;
                    end
                end
                S_WAIT: begin
                    if (dmem.ack) begin
                        state    <= S_IDLE;
                        dmem.req <= 1'b0;
                        dmem.we  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_we    <= rw_q && is_load_op(op_q);
                        wb_addr  <= dst_q;
                        wb_data  <= is_load_op(op_q) ? ldata : addr_q;
                    end else if (timeout_hit) begin
                        state    <= S_IDLE;
                        dmem.req <= 1'b0;
                        dmem.we  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_addr  <= dst_q;
                        wb_data  <= addr_q;
                        bus_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
